// File: rtl/sa_sram_loader.sv
// Byte-stream to SRAM word packer for the systolic-array operand SRAMs.
// Packs N bytes per word, zero-pads a word cut short by s_last, one write strobe per word.
module sa_sram_loader #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sel_col,
  input  logic [12:0]    base_addr,
  input  logic [12:0]    word_count,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [7:0]     s_data,
  input  logic           s_last,
  output logic           wen_n,
  output logic           wsel,
  output logic [12:0]    waddr,
  output logic [N*8-1:0] wdata,
  output logic           busy,
  output logic           done,
  output logic [12:0]    words_written,
  output logic           early_end
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     byte_idx;
  logic [N-1:0][7:0] pack, pack_nxt;
  logic [12:0]       base_q, count_q;
  logic              ended_last;
  logic              hs, word_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    word_end  = 1'b0;
    pack_nxt  = pack;
    s_ready   = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (word_count == '0) ? DONE : FILL;
      end
      FILL: begin
        s_ready  = 1'b1;
        hs       = s_valid;
        if (hs) pack_nxt[byte_idx] = s_data;
        word_end = hs && (s_last || byte_idx == IW'(N - 1));
        if (word_end) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (ended_last || (words_written + 13'd1 == count_q)) ? DONE : FILL;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write outputs are registered at the word-completing handshake, so they are
  // valid during WRITE and hold afterwards while pack is cleared for the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_n         <= 1'b1;
      waddr         <= '0;
      wdata         <= '0;
      wsel          <= 1'b0;
      words_written <= '0;
      early_end     <= 1'b0;
      byte_idx      <= '0;
      pack          <= '0;
      base_q        <= '0;
      count_q       <= '0;
      ended_last    <= 1'b0;
    end else begin
      wen_n <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            wsel          <= sel_col;
            base_q        <= base_addr;
            count_q       <= word_count;
            words_written <= '0;
            early_end     <= 1'b0;
            byte_idx      <= '0;
            pack          <= '0;
            ended_last    <= 1'b0;
          end
        end
        FILL: begin
          if (word_end) begin
            wen_n      <= 1'b0;
            waddr      <= base_q + words_written;
            wdata      <= pack_nxt;
            ended_last <= s_last;
            if (s_last && (words_written + 13'd1 != count_q)) early_end <= 1'b1;
            pack       <= '0;
            byte_idx   <= '0;
          end else if (hs) begin
            pack     <= pack_nxt;
            byte_idx <= byte_idx + 1'b1;
          end
        end
        WRITE: words_written <= words_written + 13'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_sram_loader.sv
// Randomized scoreboard bench for sa_sram_loader: expected writes and completion
// status come from a word-level model of the byte stream.
module tb_sa_sram_loader;
  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0, sel_col = 1'b0;
  logic [12:0]    base_addr = '0, word_count = '0;
  logic           s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [7:0]     s_data = '0;
  logic           wen_n, wsel, busy, done, early_end;
  logic [12:0]    waddr, words_written;
  logic [N*8-1:0] wdata;

  sa_sram_loader #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_col(sel_col),
    .base_addr(base_addr), .word_count(word_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .wen_n(wen_n), .wsel(wsel), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .words_written(words_written), .early_end(early_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0]    addr;
    logic [N*8-1:0] data;
    logic           sel;
  } wr_t;
  typedef struct {
    logic [12:0] words;
    logic        early;
  } fin_t;

  wr_t  exp_wr[$];
  fin_t exp_fin[$];
  logic [7:0] stim[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: stream length is set by s_last or by count*N bytes.
  task automatic model(input logic [12:0] base, input int cnt, input logic sel, input int last_at);
    int nb, words;
    wr_t w;
    fin_t f;
    nb    = (last_at >= 0) ? last_at + 1 : cnt * N;
    words = (nb + N - 1) / N;
    for (int wi = 0; wi < words; wi++) begin
      w.addr = 13'((int'(base) + wi) % 8192);
      w.sel  = sel;
      w.data = '0;
      for (int b = 0; b < N; b++)
        if (wi * N + b < nb) w.data[8*b +: 8] = stim[wi*N + b];
      exp_wr.push_back(w);
    end
    f.words = 13'(words);
    f.early = (last_at >= 0) && (words != cnt);
    exp_fin.push_back(f);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!wen_n) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: waddr=%0h wdata=%0h expected no strobe", waddr, wdata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("waddr", 64'(waddr), 64'(e.addr));
          chk("wdata", 64'(wdata), 64'(e.data));
          chk("wsel", 64'(wsel), 64'(e.sel));
          chk("s_ready_in_write", 64'(s_ready), 64'd0);
        end
      end
      if (done) begin
        if (exp_fin.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: done=1 expected 0");
        end else begin
          fin_t f;
          f = exp_fin.pop_front();
          chk("words_written", 64'(words_written), 64'(f.words));
          chk("early_end", 64'(early_end), 64'(f.early));
          chk("busy_in_done", 64'(busy), 64'd1);
        end
      end
    end
  end

  task automatic fill_stim(input int n, input int first);
    stim.delete();
    for (int i = 0; i < n; i++)
      stim.push_back((first >= 0) ? 8'(first + i) : 8'($urandom_range(0, 255)));
  endtask

  task automatic run_load(input logic [12:0] base, input int cnt, input logic sel,
                          input int last_at, input bit gaps, input bit mid_start);
    int nb, i, cyc;
    bit accepted, did_start;
    model(base, cnt, sel, last_at);
    nb = (last_at >= 0) ? last_at + 1 : cnt * N;
    @(negedge clk);
    sel_col = sel; base_addr = base; word_count = 13'(cnt); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sel_col = ~sel; base_addr = 13'($urandom); word_count = 13'($urandom);
    if (cnt == 0) chk("zero_count_done", 64'(done), 64'd1);
    i = 0; cyc = 0; did_start = 1'b0;
    while (i < nb && cyc < 4000) begin
      start = 1'b0;
      if (mid_start && !did_start && i == N / 2 + 1) begin
        start = 1'b1; did_start = 1'b1;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1; s_data = stim[i]; s_last = (i == last_at);
      end
      accepted = s_valid && s_ready;
      @(negedge clk);
      cyc++;
      if (accepted) i++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    chk("bytes_accepted", 64'(i), 64'(nb));
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_wen_n"}, 64'(wen_n), 64'd1);
    chk({tag, "_waddr"}, 64'(waddr), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata), 64'd0);
    chk({tag, "_wsel"}, 64'(wsel), 64'd0);
    chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_words_written"}, 64'(words_written), 64'd0);
    chk({tag, "_early_end"}, 64'(early_end), 64'd0);
  endtask

  initial begin
    int cnt, last_at;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    fill_stim(16, 8'h01);
    run_load(13'h010, 2, 1'b0, -1, 1'b0, 1'b0);

    fill_stim(11, 8'hA0);
    run_load(13'h020, 3, 1'b0, 10, 1'b0, 1'b0);

    stim.delete();
    run_load(13'h030, 0, 1'b1, -1, 1'b0, 1'b0);

    fill_stim(16, -1);
    run_load(13'h1FFF, 2, 1'b1, -1, 1'b0, 1'b0);

    fill_stim(24, -1);
    run_load(13'h100, 3, 1'b0, -1, 1'b1, 1'b1);

    fill_stim(16, -1);
    run_load(13'h200, 2, 1'b1, 15, 1'b1, 1'b0);

    // reset after 5 bytes of word 0: no strobe, no done
    fill_stim(16, -1);
    @(negedge clk);
    base_addr = 13'h300; word_count = 13'd2; sel_col = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = stim[k];
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_state("midload_reset");
    @(negedge clk);
    rst = 1'b0;
    fill_stim(16, 8'h40);
    run_load(13'h300, 2, 1'b0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, 4);
      last_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, cnt * N - 1)) : -1;
      fill_stim(cnt * N, -1);
      run_load(13'($urandom), cnt, 1'($urandom), last_at, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("fin_queue_empty", 64'(exp_fin.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_sram_loader.md
Name: sa_sram_loader

Overview:
- Write-side feeder for the systolic-array input SRAMs: accepts a byte stream from the CPU/DMA side over a valid/ready handshake and packs N bytes into one SRAM word.
- Writes each packed word to the selected row or column operand SRAM at a programmed base address.
- Sits between the host interconnect and the SRAM write ports, which the array controller later reads through raddr_row/raddr_col.
- Pads the final partial word with zeros when the stream ends early.

Parameters:
N, 8, bytes per SRAM word (matches array dimension); N >= 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: begin load; ignored unless busy=0
sel_col  in  1  target: 0 row SRAM, 1 col SRAM; sampled at start
base_addr  in  13  first word address; sampled at start
word_count  in  13  number of N-byte words to write; sampled at start
s_valid  in  1  stream byte valid
s_ready  out  1  stream byte ready
s_data  in  8  stream byte
s_last  in  1  marks final byte of stream
wen_n  out  1  SRAM write enable, active-low, one cycle per word
wsel  out  1  registered copy of sel_col; held for the whole load
waddr  out  13  SRAM word address
wdata  out  N*8  packed word; byte i at bits [8i+7:8i]
busy  out  1  high from the cycle after start until DONE exits
done  out  1  one-cycle completion pulse
words_written  out  13  words written in the current/last load
early_end  out  1  sticky: s_last arrived before word_count words were filled; cleared at start

Behaviour:
- Reset (async, rst=1): state IDLE, s_ready=0, wen_n=1, waddr=0, wdata=0, wsel=0, busy=0, done=0, words_written=0, early_end=0, byte counter=0.
- States:
  - IDLE -> FILL on start when word_count!=0.
  - IDLE -> DONE on start when word_count==0; no writes occur.
  - FILL: s_ready=1. Each handshake (s_valid&&s_ready) stores s_data into lane byte_idx and increments byte_idx.
  - FILL -> WRITE when the N-th byte is accepted, or when s_last is accepted.
  - On s_last with byte_idx<N-1, the unfilled lanes are zero. Lanes are cleared at the start of every word.
  - WRITE: s_ready=0, wen_n=0 for exactly one cycle, waddr=(base_addr+words_written) mod 2^13, wdata=packed word. words_written increments at the end of this cycle.
  - WRITE -> DONE if the word was ended by s_last, or if words_written+1==word_count. Otherwise WRITE -> FILL.
  - DONE: done=1 for one cycle, busy=0 next cycle, -> IDLE.
- Timing: the first write strobe occurs the cycle after the N-th byte handshake. Full-rate throughput is one word per N+1 cycles.
- s_ready is 0 outside FILL. Bytes beyond word_count*N are never accepted. A stream that exceeds the count stalls; the upstream side must drop the excess.
- early_end is set when s_last terminates the load before word_count words are written. It is not set if s_last coincides with the last byte of word word_count.
- s_last on the final byte of the final word is normal completion.
- s_last accepted while the load stops on word_count (excess) cannot occur, because s_ready=0 after the count is reached.
- start while busy: ignored; configuration is not resampled.
- Address wrap: base_addr+index wraps modulo 8192 with no error.
- wdata/waddr hold their last values when wen_n=1. Only wen_n qualifies them.
- rst asserted mid-load: immediate return to reset values. A partial word is discarded and no write strobe is emitted.

Test Plan:
- N=8, base=0x010, count=2, sel_col=0, bytes 0x01..0x10 continuous -> wen_n low at waddr 0x010 with wdata=0x0807060504030201, then 0x011 with wdata=0x100F0E0D0C0B0A09; done pulse; words_written=2; early_end=0; wsel=0 throughout.
- count=3, 11 bytes 0xA0..0xAA, s_last on 0xAA -> two writes; second word lanes 0-2=0xA8..0xAA, lanes 3-7=0x00; done; words_written=2; early_end=1.
- count=0 start -> done one cycle after start, no wen_n strobe, busy high for one cycle only.
- base=0x1FFF, count=2, sel_col=1 -> writes at 0x1FFF then 0x0000; wsel=1 on both strobes.
- Random s_valid gaps plus a start pulse issued mid-load -> identical packed data to the gap-free case; second start ignored; s_ready low during every WRITE cycle.
- rst pulse after 5 bytes of word 0 -> all outputs at reset values, no write strobe; a fresh start then loads correctly from byte lane 0.
